// File: rtl/multi_sync_debounce_if.sv
// Signal bundle for multi_sync_debounce: raw inputs and event clears toward the
// block, debounced level, edge pulses and sticky event flags back from it.
interface multi_sync_debounce_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] in_sig;
  logic [CHANNELS-1:0] event_clr;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rising_edge;
  logic [CHANNELS-1:0] falling_edge;
  logic                any_edge;
  logic [CHANNELS-1:0] event_pending;

  modport master (
    output in_sig, event_clr,
    input  level, rising_edge, falling_edge, any_edge, event_pending
  );

  modport slave (
    input  in_sig, event_clr,
    output level, rising_edge, falling_edge, any_edge, event_pending
  );
endinterface

// File: rtl/multi_sync_debounce.sv
// Per-channel input synchroniser and debouncer with registered rise/fall pulses
// and sticky, software-clearable event flags.
module multi_sync_debounce #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input logic                   clk,
  input logic                   rst,
  multi_sync_debounce_if.slave  bus
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_sync_debounce: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_sync_debounce: SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("multi_sync_debounce: DB_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CNT_W-1:0]       cnt_q  [CHANNELS];
  logic [CNT_W-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    s;
  logic [CHANNELS-1:0]    level_q;
  logic [CHANNELS-1:0]    level_d;
  logic [CHANNELS-1:0]    rise_q;
  logic [CHANNELS-1:0]    fall_q;
  logic [CHANNELS-1:0]    pend_q;

  // Bit 0 is the first capture flop; only the last stage feeds the debouncer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.in_sig[i]};
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      // A new edge outranks a same-cycle clear.
      pend_q  <= (pend_q & ~bus.event_clr) | (level_d ^ level_q);
    end
  end

  assign bus.level         = level_q;
  assign bus.rising_edge   = rise_q;
  assign bus.falling_edge  = fall_q;
  assign bus.any_edge      = |(rise_q | fall_q);
  assign bus.event_pending = pend_q;

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Bench for multi_sync_debounce: default build plus a SYNC_STAGES=3/DB_CYCLES=1/
// CHANNELS=8 build, both checked every cycle against a sample-history model.
module tb_multi_sync_debounce;

  typedef logic [7:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_sync_debounce_if #(.CHANNELS(4)) if_a ();
  multi_sync_debounce_if #(.CHANNELS(8)) if_b ();

  multi_sync_debounce #(.CHANNELS(4), .SYNC_STAGES(2), .DB_CYCLES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  multi_sync_debounce #(.CHANNELS(8), .SYNC_STAGES(3), .DB_CYCLES(1)) u_sweep (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: h[d] is the raw input sampled d+1 edges ago. The synchronised value
  // seen at an edge is the sample taken SYNC_STAGES edges earlier; a bit flips
  // when the last DB_CYCLES synchronised values all disagree with its level.
  function automatic vec_t next_level(input vec_t h [16], input int first,
                                      input int db, input vec_t lvl);
    vec_t flip;
    flip = '1;
    for (int j = 0; j < db; j++) flip &= h[first + j] ^ lvl;
    return lvl ^ flip;
  endfunction

  vec_t ha [16];
  vec_t hb [16];
  vec_t ml_a, mr_a, mf_a, mp_a, nl_a;
  vec_t ml_b, mr_b, mf_b, mp_b, nl_b;

  always_comb nl_a = next_level(ha, 1, 4, ml_a);
  always_comb nl_b = next_level(hb, 2, 1, ml_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 16; d++) begin
        ha[d] <= '0;
        hb[d] <= '0;
      end
      {ml_a, mr_a, mf_a, mp_a} <= '0;
      {ml_b, mr_b, mf_b, mp_b} <= '0;
    end else begin
      for (int d = 15; d > 0; d--) begin
        ha[d] <= ha[d-1];
        hb[d] <= hb[d-1];
      end
      ha[0] <= vec_t'(if_a.in_sig);
      hb[0] <= if_b.in_sig;
      ml_a  <= nl_a;
      mr_a  <= nl_a & ~ml_a;
      mf_a  <= ~nl_a & ml_a;
      mp_a  <= (mp_a & ~vec_t'(if_a.event_clr)) | (nl_a ^ ml_a);
      ml_b  <= nl_b;
      mr_b  <= nl_b & ~ml_b;
      mf_b  <= ~nl_b & ml_b;
      mp_b  <= (mp_b & ~if_b.event_clr) | (nl_b ^ ml_b);
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("a_level",   vec_t'(if_a.level),         ml_a);
      check("a_rise",    vec_t'(if_a.rising_edge),   mr_a);
      check("a_fall",    vec_t'(if_a.falling_edge),  mf_a);
      check("a_any",     vec_t'(if_a.any_edge),      vec_t'(|(mr_a | mf_a)));
      check("a_pending", vec_t'(if_a.event_pending), mp_a);
      check("a_excl",    vec_t'(if_a.rising_edge & if_a.falling_edge), 8'h00);
      check("b_level",   if_b.level,         ml_b);
      check("b_rise",    if_b.rising_edge,   mr_b);
      check("b_fall",    if_b.falling_edge,  mf_b);
      check("b_any",     vec_t'(if_b.any_edge), vec_t'(|(mr_b | mf_b)));
      check("b_pending", if_b.event_pending, mp_b);
      check("b_excl",    if_b.rising_edge & if_b.falling_edge, 8'h00);
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    if_a.in_sig = '0; if_a.event_clr = '0;
    if_b.in_sig = '0; if_b.event_clr = '0;
    tick(2);
    check("reset_level",   vec_t'(if_a.level), 8'h00);
    check("reset_pending", vec_t'(if_a.event_pending), 8'h00);
    check("reset_any",     vec_t'(if_a.any_edge), 8'h00);
    rst = 1'b0;
    started = 1'b1;

    // Single channel rise latency
    if_a.in_sig = 4'b0001;
    tick(5);
    check("t1_level_early", vec_t'(if_a.level), 8'h00);
    tick();
    check("t1_level", vec_t'(if_a.level), 8'h01);
    check("t1_rise",  vec_t'(if_a.rising_edge), 8'h01);
    check("t1_any",   vec_t'(if_a.any_edge), 8'h01);
    check("t1_pend",  vec_t'(if_a.event_pending), 8'h01);
    tick();
    check("t1_rise_once", vec_t'(if_a.rising_edge), 8'h00);
    check("t1_pend_held", vec_t'(if_a.event_pending), 8'h01);

    // Clear with no competing edge
    if_a.event_clr = 4'b0001;
    tick();
    if_a.event_clr = '0;
    check("t3_clear", vec_t'(if_a.event_pending), 8'h00);

    // Glitch of 3 cycles rejected, 4 cycles accepted
    if_a.in_sig[1] = 1'b1;
    tick(3);
    if_a.in_sig[1] = 1'b0;
    tick(10);
    check("t2_glitch_level", vec_t'(if_a.level[1]), 8'h00);
    check("t2_glitch_pend",  vec_t'(if_a.event_pending[1]), 8'h00);
    rise_cnt = 0; fall_cnt = 0;
    if_a.in_sig[1] = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k == 4) if_a.in_sig[1] = 1'b0;
      tick();
      rise_cnt += int'(if_a.rising_edge[1]);
      fall_cnt += int'(if_a.falling_edge[1]);
    end
    check("t2_rise_count", vec_t'(rise_cnt), 8'd1);
    check("t2_fall_count", vec_t'(fall_cnt), 8'd1);

    // Clear in the same cycle as a new edge: the edge wins
    if_a.in_sig[2] = 1'b1;
    tick(5);
    if_a.event_clr = 4'b0100;
    tick();
    if_a.event_clr = '0;
    check("t3_rise2", vec_t'(if_a.rising_edge[2]), 8'h01);
    check("t3_pend2", vec_t'(if_a.event_pending[2]), 8'h01);

    // Reset mid-debounce, input held across release
    if_a.in_sig[3] = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_level", vec_t'(if_a.level), 8'h00);
    check("t4_rst_pend",  vec_t'(if_a.event_pending), 8'h00);
    check("t4_rst_rise",  vec_t'(if_a.rising_edge | if_a.falling_edge), 8'h00);
    tick();
    rst = 1'b0;
    tick(5);
    check("t4_level_early", vec_t'(if_a.level[3]), 8'h00);
    tick();
    check("t4_level", vec_t'(if_a.level[3]), 8'h01);
    check("t4_rise",  vec_t'(if_a.rising_edge[3]), 8'h01);

    // Sweep build: single-sample pulse passes with 3-edge latency
    if_b.in_sig = 8'h01;
    tick();
    if_b.in_sig = 8'h00;
    tick(2);
    check("t6_level_early", if_b.level, 8'h00);
    tick();
    check("t6_level", if_b.level, 8'h01);
    check("t6_rise",  if_b.rising_edge, 8'h01);
    tick();
    check("t6_level_back", if_b.level, 8'h00);
    check("t6_fall", if_b.falling_edge, 8'h01);

    // All channels simultaneously
    if_a.in_sig = '0;
    tick(12);
    if_a.event_clr = '1;
    tick();
    if_a.event_clr = '0;
    if_a.in_sig = '1;
    tick(6);
    check("t5_level", vec_t'(if_a.level), 8'h0f);
    check("t5_rise",  vec_t'(if_a.rising_edge), 8'h0f);
    check("t5_any",   vec_t'(if_a.any_edge), 8'h01);
    check("t5_pend",  vec_t'(if_a.event_pending), 8'h0f);
    tick();
    check("t5_rise_once", vec_t'(if_a.rising_edge), 8'h00);
    check("t5_any_once",  vec_t'(if_a.any_edge), 8'h00);

    // Random phase: slow-flipping bits on the default build, raw noise on the sweep
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 7) == 0) if_a.in_sig[c] = ~if_a.in_sig[c];
      end
      if_a.event_clr = 4'($urandom & $urandom);
      if_b.in_sig    = 8'($urandom);
      if_b.event_clr = 8'($urandom & $urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_sync_debounce.md
Name: multi_sync_debounce

Overview:
Parametrised successor to the single-bit input synchroniser/edge detector. Synchronises CHANNELS asynchronous inputs through a configurable-depth flop chain and debounces each channel with a per-channel stability counter. Produces a clean level, one-cycle rise/fall pulses, and a sticky per-channel event flag with software clear. Sits between board I/O (buttons, switches, external strobes) and control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DB_CYCLES, 4, consecutive cycles the synchronised value must differ from level before level changes (>=1; 1 = no filtering)
CNT_W, $clog2(DB_CYCLES+1), localparam, debounce counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_sig  in  CHANNELS  raw asynchronous inputs
event_clr  in  CHANNELS  per-channel clear of event_pending, sampled on clk
level  out  CHANNELS  debounced, synchronised level
rising_edge  out  CHANNELS  one-cycle pulse on level 0->1
falling_edge  out  CHANNELS  one-cycle pulse on level 1->0
any_edge  out  1  OR of all rising_edge and falling_edge bits
event_pending  out  CHANNELS  sticky: set on any edge of channel, held until cleared

Behaviour:
- Reset (rst=1, asynchronous assert): all sync flops, counters, level, rising_edge, falling_edge and event_pending go to 0 immediately. any_edge=0. Reset mid-debounce discards the count. No pulses are generated during reset.
- Sync chain: per channel, SYNC_STAGES flops in series. s[i] is the last stage. The other stages are not used by any logic.
- Debounce, per channel, with state {level, cnt}:
  - s==level: cnt<=0, level held.
  - s!=level and cnt<DB_CYCLES-1: cnt<=cnt+1.
  - s!=level and cnt==DB_CYCLES-1: level<=s, cnt<=0.
  - A return of s to level before the terminal count resets cnt, so glitches shorter than DB_CYCLES cycles at s are ignored.
- Latency: in_sig is first sampled high at edge 0 and held. s rises after edge SYNC_STAGES-1. level rises after edge SYNC_STAGES+DB_CYCLES-1 (defaults: after edge 5).
- Edge pulses are registered and updated in the same clock as level:
  - rising_edge[i]=1 for exactly the first cycle level[i] reads 1 after reading 0.
  - falling_edge[i] is the mirror of rising_edge[i].
  - rising_edge[i] and falling_edge[i] are never 1 together.
  - Minimum spacing between pulses on one channel is DB_CYCLES cycles.
- any_edge is combinational OR of registered pulse bits, so it is high in the same cycle as the pulses.
- event_pending[i]:
  - Set on the edge where rising_edge[i] or falling_edge[i] is set.
  - Cleared on an edge with event_clr[i]=1.
  - Set and clear in the same cycle: set wins (stays 1).
  - event_clr on an already-clear bit has no effect.
- Channels are fully independent. Simultaneous edges on several channels each pulse and latch.
- Post-reset: if in_sig is held high through reset release, level rises after the normal latency and a rising_edge pulse is produced. This is intended.
- Illegal parameters (SYNC_STAGES<2, DB_CYCLES<1, CHANNELS<1) cause an elaboration-time error.

Test Plan:
1. Defaults. rst pulse, then in_sig[0] 0->1 sampled at edge 0 and held -> level[0]=1 after edge 5; rising_edge[0]=1 and any_edge=1 for exactly one cycle; event_pending[0]=1 and stays 1; other channels remain 0.
2. Glitch rejection. in_sig[1] high for 3 cycles then low (DB_CYCLES=4) -> level[1], rising_edge[1] and event_pending[1] stay 0. Then high for 4 cycles -> level[1] rises, then falls 4 cycles after s returns low; one rise pulse and one fall pulse observed.
3. Event clear priority:
   - Pulse event_clr[0] with no edge -> event_pending[0] clears next cycle.
   - Assert event_clr[2] in the same cycle as a rising_edge[2] set -> event_pending[2] remains 1.
4. Reset mid-operation. in_sig[3] high, assert rst after 3 cycles (cnt=1) -> all outputs 0 immediately. Release with input still high -> level[3] rises exactly SYNC_STAGES+DB_CYCLES edges after release; one rising pulse.
5. Multi-channel simultaneous. All 4 in_sig rise on the same sample -> all level bits rise on the same edge; rising_edge=4'b1111 for one cycle; any_edge high for that one cycle; event_pending=4'b1111.
6. Parameter sweep (SYNC_STAGES=3, DB_CYCLES=1, CHANNELS=8). Single-cycle-wide input toggles -> level follows s with latency 3 edges; pulses alternate rise/fall with no cycle carrying both.
